// File: rtl/hazard_grid_sequencer_pkg.sv
// Shared geometry, sizing and type definitions for the hazard grid sequencer.
package hazard_pkg;
  localparam int IMG_WIDTH   = 26;
  localparam int IMG_HEIGHT  = 8;
  localparam int GRID_COLS   = 8;
  localparam int GRID_ROWS   = 4;
  localparam int CELL_WIDTH  = 3;
  localparam int CELL_HEIGHT = 2;
  localparam int MAX_HAZARDS = 16;
  localparam int COORD_W     = 11;
  localparam int NUM_CELLS   = GRID_ROWS * GRID_COLS;
  localparam int CNT_W       = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_EMIT
  } state_t;

  typedef struct packed {
    logic [COORD_W-1:0] top;
    logic [COORD_W-1:0] left;
    logic [COORD_W-1:0] bottom;
    logic [COORD_W-1:0] right;
  } box_t;
endpackage

// File: rtl/hazard_grid_sequencer_if.sv
// Box-in / grid-out handshake bundle; master is the box producer and result consumer.
interface hazard_grid_sequencer_if;
  import hazard_pkg::*;
  logic                 in_valid;
  logic                 in_ready;
  logic [COORD_W-1:0]   in_top;
  logic [COORD_W-1:0]   in_left;
  logic [COORD_W-1:0]   in_bottom;
  logic [COORD_W-1:0]   in_right;
  logic                 in_last;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [15:0]          vec1;
  logic [15:0]          vec2;
  logic [CNT_W-1:0]     hazard_count;
  logic                 overflow;

  modport master (
    output in_valid, in_top, in_left, in_bottom, in_right, in_last, flush, out_ready,
    input  in_ready, out_valid, vec1, vec2, hazard_count, overflow
  );
  modport slave (
    input  in_valid, in_top, in_left, in_bottom, in_right, in_last, flush, out_ready,
    output in_ready, out_valid, vec1, vec2, hazard_count, overflow
  );
endinterface

// File: rtl/hazard_grid_sequencer_cell_mask.sv
// Combinational box-to-cell overlap mask over the 4x8 grid.
module hazard_cell_mask
  import hazard_pkg::*;
(
  input  box_t                 box,
  output logic [NUM_CELLS-1:0] mask
);
  logic inverted;
  assign inverted = (box.top > box.bottom) || (box.left > box.right);

  for (genvar r = 0; r < GRID_ROWS; r++) begin : g_row
    for (genvar c = 0; c < GRID_COLS; c++) begin : g_col
      localparam logic [COORD_W-1:0] RT = COORD_W'(r * CELL_HEIGHT);
      localparam logic [COORD_W-1:0] RB = COORD_W'(r * CELL_HEIGHT + CELL_HEIGHT - 1);
      localparam logic [COORD_W-1:0] CL = COORD_W'(c * CELL_WIDTH);
      localparam logic [COORD_W-1:0] CR = COORD_W'(c * CELL_WIDTH + CELL_WIDTH - 1);
      // Inverted boxes can still pass the overlap test, so they are masked explicitly.
      assign mask[r*GRID_COLS+c] = !inverted &&
        !(box.bottom < RB - 1'b1 + 1'b1 - (RB - RT) || box.top > RB ||
          box.right < CL || box.left > CR);
    end
  end
endmodule

// File: rtl/hazard_grid_sequencer.sv
// Accumulates hazard boxes into a 32-cell occupancy grid and emits one result per frame.
module hazard_grid_sequencer
  import hazard_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COORD_W-1:0] in_top,
  input  logic [COORD_W-1:0] in_left,
  input  logic [COORD_W-1:0] in_bottom,
  input  logic [COORD_W-1:0] in_right,
  input  logic               in_last,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [15:0]        vec1,
  output logic [15:0]        vec2,
  output logic [CNT_W-1:0]   hazard_count,
  output logic               overflow
);
  state_t               state_q, state_d;
  logic [NUM_CELLS-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 in_ready_q, in_ready_d;
  logic [NUM_CELLS-1:0] box_mask;
  logic                 accept;

  hazard_cell_mask u_mask (
    .box  ('{top: in_top, left: in_left, bottom: in_bottom, right: in_right}),
    .mask (box_mask)
  );

  // in_ready is low in EMIT, so an accept can only happen in IDLE/ACCUM.
  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE, S_ACCUM: begin
        if (accept) begin
          state_d = S_ACCUM;
          if (cnt_q == CNT_W'(MAX_HAZARDS)) begin
            ovf_d = 1'b1;
          end else begin
            acc_d = acc_q | box_mask;
            cnt_d = cnt_q + 1'b1;
          end
        end
        if ((accept && in_last) || flush) state_d = S_EMIT;
      end
      S_EMIT: begin
        if (out_ready) begin
          state_d = S_IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d = (state_d != S_EMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = (state_q == S_EMIT);
  assign vec1         = acc_q[15:0];
  assign vec2         = acc_q[31:16];
  assign hazard_count = cnt_q;
  assign overflow     = ovf_q;
endmodule

// File: tb/tb_hazard_grid_sequencer.sv
// Directed bench for hazard_grid_sequencer with hand-computed grid results.
module tb_hazard_grid_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;

  hazard_grid_sequencer_if bus ();

  hazard_grid_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (bus.in_valid),
    .in_ready     (bus.in_ready),
    .in_top       (bus.in_top),
    .in_left      (bus.in_left),
    .in_bottom    (bus.in_bottom),
    .in_right     (bus.in_right),
    .in_last      (bus.in_last),
    .flush        (bus.flush),
    .out_valid    (bus.out_valid),
    .out_ready    (bus.out_ready),
    .vec1         (bus.vec1),
    .vec2         (bus.vec2),
    .hazard_count (bus.hazard_count),
    .overflow     (bus.overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int t, input int l, input int b, input int r,
                      input logic last, input logic fl);
    bus.in_valid  = 1'b1;
    bus.in_top    = 11'(t);
    bus.in_left   = 11'(l);
    bus.in_bottom = 11'(b);
    bus.in_right  = 11'(r);
    bus.in_last   = last;
    bus.flush     = fl;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [15:0] v1, input logic [15:0] v2,
                           input logic [4:0] cnt, input logic ovf);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_in_ready"},  32'(bus.in_ready), 32'd0);
    check({tag, "_vec1"},      32'(bus.vec1), 32'(v1));
    check({tag, "_vec2"},      32'(bus.vec2), 32'(v2));
    check({tag, "_count"},     32'(bus.hazard_count), 32'(cnt));
    check({tag, "_overflow"},  32'(bus.overflow), 32'(ovf));
  endtask

  task automatic handshake(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "_hs_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_hs_in_ready"},  32'(bus.in_ready), 32'd1);
    check({tag, "_hs_vecs"},      {bus.vec2, bus.vec1}, 32'd0);
    check({tag, "_hs_count"},     32'(bus.hazard_count), 32'd0);
    check({tag, "_hs_overflow"},  32'(bus.overflow), 32'd0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_in_ready"},  32'(bus.in_ready), 32'd0);
    check({tag, "_vecs"},      {bus.vec2, bus.vec1}, 32'd0);
    check({tag, "_count"},     32'(bus.hazard_count), 32'd0);
    check({tag, "_overflow"},  32'(bus.overflow), 32'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_top = '0; bus.in_left = '0; bus.in_bottom = '0;
    bus.in_right = '0; bus.in_last = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b0;

    #2 check_reset("rst");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_in_ready", 32'(bus.in_ready), 32'd1);
    check("rel_out_valid", 32'(bus.out_valid), 32'd0);

    // single top-left pixel box
    send(0, 0, 0, 0, 1'b1, 1'b0);
    check_out("origin", 16'h0001, 16'h0000, 5'd1, 1'b0);
    handshake("origin");

    // bottom-right cell; columns 24..25 contribute nothing
    send(6, 21, 7, 25, 1'b1, 1'b0);
    check_out("corner", 16'h0000, 16'h8000, 5'd1, 1'b0);
    handshake("corner");

    // two boxes merged
    send(2, 3, 3, 5, 1'b0, 1'b0);
    check("two_mid_out_valid", 32'(bus.out_valid), 32'd0);
    send(0, 0, 7, 2, 1'b1, 1'b0);
    check_out("two", 16'h0301, 16'h0101, 5'd2, 1'b0);
    handshake("two");

    // 17 boxes back to back: saturation and overflow
    for (int i = 0; i < 17; i++) begin
      send(0, 0, 0, 0, (i == 16), 1'b0);
      if (i == 15) begin
        check("sat16_count", 32'(bus.hazard_count), 32'd16);
        check("sat16_overflow", 32'(bus.overflow), 32'd0);
      end
    end
    check_out("sat", 16'h0001, 16'h0000, 5'd16, 1'b1);
    handshake("sat");

    // EMIT held with out_ready low while boxes and flush are offered
    send(0, 0, 7, 2, 1'b1, 1'b0);
    check_out("hold0", 16'h0101, 16'h0101, 5'd1, 1'b0);
    bus.in_valid = 1'b1; bus.in_top = '0; bus.in_left = 11'd9; bus.in_bottom = 11'd7;
    bus.in_right = 11'd20; bus.flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_out("hold", 16'h0101, 16'h0101, 5'd1, 1'b0);
    end
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    handshake("hold");

    // inverted and off-grid boxes are counted but mark nothing
    send(5, 0, 2, 3, 1'b0, 1'b0);
    send(0, 4, 1, 3, 1'b0, 1'b0);
    send(0, 24, 7, 25, 1'b1, 1'b0);
    check_out("empty", 16'h0000, 16'h0000, 5'd3, 1'b0);
    handshake("empty");

    // flush together with an accepted box includes the box
    send(0, 0, 0, 0, 1'b0, 1'b1);
    check_out("flush_box", 16'h0001, 16'h0000, 5'd1, 1'b0);
    handshake("flush_box");

    // flush from IDLE emits an empty grid
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check_out("flush_idle", 16'h0000, 16'h0000, 5'd0, 1'b0);
    handshake("flush_idle");

    // reset in the middle of a frame discards the partial result
    send(0, 0, 0, 0, 1'b0, 1'b0);
    send(2, 3, 3, 5, 1'b0, 1'b0);
    check("pre_rst_count", 32'(bus.hazard_count), 32'd2);
    #2 rst_n = 1'b0;
    #1 check_reset("mid_rst");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_rel_in_ready", 32'(bus.in_ready), 32'd1);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check_out("post_rst", 16'h0000, 16'h0000, 5'd0, 1'b0);
    handshake("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
